toeplitz_stream: RTL and testbench

- Streaming, runtime-seeded Toeplitz extractor. Parametrised successor of toeplitz_p.
- The seed is no longer fixed at build time: it is loaded through a port at run time.
- Input is WIDTH raw bits per beat under a valid/ready handshake.
- Each N-bit block produces an L-bit result on a registered output with valid/ready backpressure.
- Sits between the raw-bit sampler and the serializer/packer. The output register lets the next block be absorbed while the previous result waits downstream.

---
 rtl/toeplitz_pkg.sv | 28 ++
 rtl/toeplitz_seed_reg.sv | 68 ++++++
 rtl/toeplitz_stream.sv | 143 ++++++++++++++
 tb/tb_toeplitz_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toeplitz_pkg.sv
// Shared types and sizing helpers for the streaming Toeplitz extractor.
package toeplitz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        FULL
    } state_t;

    function automatic int beats_per_block(input int n, input int w);
        return n / w;
    endfunction

    function automatic int beats_per_seed(input int n, input int l, input int w);
        return (n + l) / w;
    endfunction

    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic bit params_ok(input int n, input int l, input int w, input int slen);
        return (w > 0) && (n % w == 0) && ((n + l) % w == 0)
            && (l > 0) && (l < n) && (slen == n + l);
    endfunction

endpackage

// File: rtl/toeplitz_seed_reg.sv
// Runtime seed store: shifts WIDTH bits per strobe so s_0 lands at bit 0.
module toeplitz_seed_reg
    import toeplitz_pkg::*;
#(
    parameter int N     = 256,
    parameter int L     = 128,
    parameter int WIDTH = 2,
    parameter int SLEN  = N + L
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we_i,
    input  logic             first_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [SLEN-1:0]  seed_o,
    output logic             ok_o,
    output logic             last_o
);

    localparam int BPS = beats_per_seed(N, L, WIDTH);
    localparam int CW  = cnt_width(BPS);

    logic [SLEN-1:0]  seed_q, seed_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic [WIDTH-1:0] chunk;

    assign last_o = (cnt_q == CW'(BPS - 1));
    assign seed_o = seed_q;
    assign ok_o   = ok_q;

    always_comb begin
        for (int w = 0; w < WIDTH; w++) begin
            chunk[w] = data_i[WIDTH-1-w];
        end
    end

    always_comb begin
        seed_d = seed_q;
        cnt_d  = cnt_q;
        ok_d   = ok_q;
        if (we_i) begin
            seed_d = {chunk, seed_q[SLEN-1:WIDTH]};
            if (first_i) begin
                ok_d = 1'b0;
            end
            if (last_o) begin
                cnt_d = '0;
                ok_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seed_q <= '0;
            cnt_q  <= '0;
            ok_q   <= 1'b0;
        end else begin
            seed_q <= seed_d;
            cnt_q  <= cnt_d;
            ok_q   <= ok_d;
        end
    end

endmodule

// File: rtl/toeplitz_stream.sv
// Streaming Toeplitz extractor: WIDTH raw bits per beat, L-bit result per N-bit block.
module toeplitz_stream
    import toeplitz_pkg::*;
#(
    parameter int N     = 256,
    parameter int L     = 128,
    parameter int WIDTH = 2,
    parameter int SLEN  = N + L
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_data,
    output logic             seed_ok,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [L-1:0]     q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy
);

    localparam int BPB = beats_per_block(N, WIDTH);
    localparam int BCW = cnt_width(BPB);

    if (!params_ok(N, L, WIDTH, SLEN)) begin : g_bad_params
        $error("toeplitz_stream: illegal N/L/WIDTH/SLEN combination");
    end

    state_t          state_q, state_d;
    logic [BCW-1:0]  beat_q, beat_d;
    logic [SLEN-1:0] win_q, win_d, cur_win;
    logic [L-1:0]    acc_q, acc_d, res;
    logic [L-1:0]    q_q, q_d;
    logic            qv_q, qv_d;
    logic [SLEN-1:0] seed;
    logic            seed_last, seed_load;
    logic            rdy, accept, blk_last;

    assign rdy      = seed_ok & ((state_q == IDLE) | (state_q == RUN));
    assign accept   = in_valid & rdy;
    assign blk_last = (beat_q == BCW'(BPB - 1));
    // An input beat taken in IDLE owns the cycle; a coincident seed strobe is dropped.
    assign seed_load = seed_we & ((state_q == LOAD) | ((state_q == IDLE) & ~accept));

    toeplitz_seed_reg #(
        .N(N), .L(L), .WIDTH(WIDTH), .SLEN(SLEN)
    ) u_seed (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (seed_load),
        .first_i (state_q == IDLE),
        .data_i  (seed_data),
        .seed_o  (seed),
        .ok_o    (seed_ok),
        .last_o  (seed_last)
    );

    always_comb begin
        cur_win = (state_q == IDLE) ? seed : win_q;
        res     = (state_q == IDLE) ? '0 : acc_q;
        for (int w = 0; w < WIDTH; w++) begin
            if (in_data[WIDTH-1-w]) begin
                res = res ^ cur_win[w +: L];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        win_d   = win_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qv_d    = qv_q;
        if (qv_q && q_ready) begin
            qv_d = 1'b0;
        end
        unique case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    win_d = cur_win >> WIDTH;
                    if (blk_last) begin
                        beat_d = '0;
                        if (!qv_q || q_ready) begin
                            q_d     = res;
                            qv_d    = 1'b1;
                            acc_d   = '0;
                            state_d = IDLE;
                        end else begin
                            acc_d   = res;
                            state_d = FULL;
                        end
                    end else begin
                        beat_d  = beat_q + BCW'(1);
                        acc_d   = res;
                        state_d = RUN;
                    end
                end else if (state_q == IDLE && seed_we) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (seed_we && seed_last) begin
                    state_d = IDLE;
                end
            end
            FULL: begin
                if (q_ready) begin
                    q_d     = acc_q;
                    qv_d    = 1'b1;
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            win_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            win_q   <= win_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
        end
    end

    assign in_ready = rdy;
    assign q        = q_q;
    assign q_valid  = qv_q;
    assign busy     = (state_q == RUN) | (state_q == FULL);

endmodule

// File: tb/tb_toeplitz_stream.sv
// Scoreboard bench for toeplitz_stream with a small N=8, L=4, WIDTH=2 build.
module tb_toeplitz_stream;

    localparam int N    = 8;
    localparam int L    = 4;
    localparam int W    = 2;
    localparam int SLEN = N + L;
    localparam int BPB  = N / W;
    localparam int BPS  = SLEN / W;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         seed_we;
    logic [W-1:0] seed_data;
    logic         seed_ok;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [L-1:0] q;
    logic         q_valid;
    logic         q_ready;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [L-1:0]    exp_q[$];
    logic            rand_qr    = 1'b0;
    logic            stall_prev = 1'b0;
    logic [L-1:0]    q_prev     = '0;
    logic [SLEN-1:0] model_seed = '0;

    always #5 clk = ~clk;

    toeplitz_stream #(
        .N(N), .L(L), .WIDTH(W), .SLEN(SLEN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed_we   (seed_we),
        .seed_data (seed_data),
        .seed_ok   (seed_ok),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy)
    );

    function automatic logic [L-1:0] model(input logic [N-1:0] x, input logic [SLEN-1:0] s);
        logic [L-1:0] y;
        y = '0;
        for (int j = 0; j < L; j++) begin
            for (int i = 0; i < N; i++) begin
                y[j] = y[j] ^ (x[i] & s[i+j]);
            end
        end
        return y;
    endfunction

    task automatic tick();
        logic [L-1:0] e;
        @(negedge clk);
        if (stall_prev) begin
            n_checks++;
            if (q_valid !== 1'b1 || q !== q_prev) begin
                n_fail++;
                $display("FAIL stall_hold: q_valid=%b q=%h, required q_valid=1 q=%h", q_valid, q, q_prev);
            end
        end
        if (q_valid === 1'b1 && q_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: q=%h, required no output", q);
            end else begin
                e = exp_q.pop_front();
                if (q !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard: q=%h, required %h", q, e);
                end
            end
        end
        stall_prev = q_valid && !q_ready;
        q_prev     = q;
        @(posedge clk);
        #1;
        cyc++;
        if (rand_qr) q_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load_seed(input logic [SLEN-1:0] s, input bit gaps);
        for (int b = 0; b < BPS; b++) begin
            seed_we = 1'b1;
            for (int w = 0; w < W; w++) seed_data[W-1-w] = s[b*W+w];
            tick();
            seed_we = 1'b0;
            if (b == 0) begin
                n_checks++;
                if (seed_ok !== 1'b0) begin
                    n_fail++;
                    $display("FAIL seed_ok_clear: seed_ok=%b, required 0", seed_ok);
                end
            end
            if (gaps && $urandom_range(0, 1) == 1) tick();
        end
        n_checks++;
        if (seed_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL seed_ok_set: seed_ok=%b, required 1", seed_ok);
        end
        model_seed = s;
    endtask

    task automatic send_block(input logic [N-1:0] x, input logic [L-1:0] e, input bit pulse_seed);
        int t;
        exp_q.push_back(e);
        for (int b = 0; b < BPB; b++) begin
            in_valid = 1'b1;
            for (int w = 0; w < W; w++) in_data[W-1-w] = x[b*W+w];
            t = 0;
            while (in_ready !== 1'b1 && t < 50) begin
                tick();
                t++;
            end
            if (t == 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout: in_ready=%b, required 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            seed_we   = pulse_seed && (b == 1);
            seed_data = '0;
            tick();
            seed_we = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 60) begin
            tick();
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (q_valid !== 1'b0 || seed_ok !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || q !== '0) begin
            n_fail++;
            $display("FAIL reset_state: qv=%b ok=%b busy=%b rdy=%b q=%h, required all 0",
                     q_valid, seed_ok, busy, in_ready, q);
        end
        reset_n = 1'b1;
        in_valid = 1'b1;
        in_data = 2'b11;
        tick();
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_seed_accept: rdy=%b busy=%b, required 0 0", in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        q_ready = 1'b0;
        load_seed('1, 1'b1);
        send_block(8'b0000_0001, 4'b1111, 1'b0);
        n_checks++;
        if (q_valid !== 1'b1 || q !== 4'b1111 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: qv=%b q=%b busy=%b, required 1 1111 0", q_valid, q, busy);
        end
        q_ready = 1'b1;
        tick();
        n_checks++;
        if (q_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: q_valid=%b, required 0", q_valid);
        end
    endtask

    task automatic test_shift();
        q_ready = 1'b1;
        load_seed(12'b0000_0000_1000, 1'b0);
        send_block(8'b0000_1000, 4'b0001, 1'b0);
        load_seed(12'b0000_0010_0000, 1'b1);
        send_block(8'b0000_1000, 4'b0100, 1'b0);
        drain();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] x1, x2;
        logic [L-1:0] e1, e2;
        q_ready = 1'b0;
        load_seed(12'hA5C, 1'b0);
        x1 = 8'h35;
        x2 = 8'hC2;
        e1 = model(x1, model_seed);
        e2 = model(x2, model_seed);
        send_block(x1, e1, 1'b0);
        send_block(x2, e2, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || q_valid !== 1'b1 || q !== e1) begin
            n_fail++;
            $display("FAIL full_stall: busy=%b rdy=%b qv=%b q=%h, required 1 0 1 %h",
                     busy, in_ready, q_valid, q, e1);
        end
        in_valid = 1'b1;
        in_data  = 2'b10;
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_blocks_input: rdy=%b busy=%b, required 0 1", in_ready, busy);
        end
        in_valid = 1'b0;
        q_ready = 1'b1;
        tick();
        n_checks++;
        if (q_valid !== 1'b1 || q !== e2) begin
            n_fail++;
            $display("FAIL full_release: qv=%b q=%h, required 1 %h", q_valid, q, e2);
        end
        tick();
        n_checks++;
        if (q_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty: q_valid=%b, required 0", q_valid);
        end
        drain();
    endtask

    task automatic test_reload();
        q_ready = 1'b1;
        load_seed('1, 1'b0);
        send_block(8'h7F, 4'b1111, 1'b1);
        n_checks++;
        if (seed_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL run_seed_we_ok: seed_ok=%b, required 1", seed_ok);
        end
        send_block(8'h01, 4'b1111, 1'b0);
        load_seed('0, 1'b1);
        for (int k = 0; k < 2; k++) send_block(N'($urandom), 4'b0000, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] x;
        int c0;
        q_ready = 1'b1;
        load_seed(SLEN'($urandom), 1'b0);
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            x = N'($urandom);
            send_block(x, model(x, model_seed), 1'b0);
        end
        n_checks++;
        if (cyc - c0 != 6 * BPB) begin
            n_fail++;
            $display("FAIL no_bubbles: cycles=%0d, required %0d", cyc - c0, 6 * BPB);
        end
        drain();
    endtask

    task automatic test_random_bp();
        logic [N-1:0] x;
        load_seed(SLEN'($urandom), 1'b1);
        rand_qr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            x = N'($urandom);
            send_block(x, model(x, model_seed), 1'b0);
        end
        rand_qr = 1'b0;
        q_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] x;
        q_ready = 1'b1;
        load_seed(SLEN'($urandom), 1'b0);
        in_valid = 1'b1;
        in_data  = 2'b01;
        tick();
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        n_checks++;
        if (q_valid !== 1'b0 || seed_ok !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: qv=%b ok=%b busy=%b, required 0 0 0", q_valid, seed_ok, busy);
        end
        stall_prev = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        load_seed(SLEN'($urandom), 1'b0);
        x = N'($urandom);
        send_block(x, model(x, model_seed), 1'b0);
        drain();
    endtask

    initial begin
        reset_n   = 1'b0;
        seed_we   = 1'b0;
        seed_data = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        q_ready   = 1'b0;
        test_reset();
        test_basic();
        test_shift();
        test_backpressure();
        test_reload();
        test_back_to_back();
        test_random_bp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
